rf_writeback_queue: RTL and testbench

RF_WRITEBACK_QUEUE -- requirements
Module: rf_writeback_queue

---
 rtl/rf_writeback_queue.sv | 123 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: FIFO between writeback sources and a register-file write port; rev 1.0.
// Optional RF_WBQ_FORWARD_EN adds a read-forwarding lookup (FWD_ADD/FWD_HIT/FWD_DATA).
`default_nettype none

module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [AW-1:0]             IN_WADD,
  input  logic [DW-1:0]             IN_DATA,
  output logic                      WEN,
  output logic [AW-1:0]             WADD,
  output logic [DW-1:0]             DATAIN,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      FULL,
  output logic                      EMPTY
`ifdef RF_WBQ_FORWARD_EN
  ,
  input  logic [AW-1:0]             FWD_ADD,
  output logic                      FWD_HIT,
  output logic [DW-1:0]             FWD_DATA
`endif
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [AW-1:0]        addr_mem_q [DEPTH];
  logic [DW-1:0]        data_mem_q [DEPTH];
  logic [c_ptr_w-1:0]   head_q, head_d, tail_q, tail_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  logic                 wen_q, wen_d;
  logic [AW-1:0]        wadd_q, wadd_d;
  logic [DW-1:0]        datain_q, datain_d;
  logic                 full, empty, do_push, do_pop;

  always_comb begin
    full     = (count_q == c_depth);
    empty    = (count_q == '0);
    // Push is refused when full even though the head pops this edge.
    do_push  = IN_VALID && !full;
    do_pop   = !empty;
    head_d   = head_q;
    tail_d   = tail_q;
    wen_d    = 1'b0;
    wadd_d   = wadd_q;
    datain_d = datain_q;
    if (do_pop) begin
      wen_d    = 1'b1;
      wadd_d   = addr_mem_q[head_q];
      datain_d = data_mem_q[head_q];
      head_d   = head_q + c_ptr_w'(1);
    end
    if (do_push) begin
      tail_d = tail_q + c_ptr_w'(1);
    end
    count_d = count_q + c_cnt_w'(do_push) - c_cnt_w'(do_pop);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      wadd_q   <= '0;
      datain_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      wadd_q   <= wadd_d;
      datain_q <= datain_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && do_push) begin
      addr_mem_q[tail_q] <= IN_WADD;
      data_mem_q[tail_q] <= IN_DATA;
    end
  end

  assign IN_READY = !full;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign COUNT    = count_q;
  assign WEN      = wen_q;
  assign WADD     = wadd_q;
  assign DATAIN   = datain_q;

`ifdef RF_WBQ_FORWARD_EN
  logic [c_ptr_w-1:0] fwd_idx;

  // Scan oldest to newest so the last match left standing is the newest.
  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_DATA = '0;
    fwd_idx  = '0;
    if (wen_q && (wadd_q == FWD_ADD)) begin
      FWD_HIT  = 1'b1;
      FWD_DATA = datain_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + c_ptr_w'(i);
      if ((c_cnt_w'(i) < count_q) && (addr_mem_q[fwd_idx] == FWD_ADD)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = data_mem_q[fwd_idx];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: queue-based reference model, directed plus random stimulus.
`default_nettype none

module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [AW-1:0] IN_WADD = '0;
  logic [DW-1:0] IN_DATA = '0;
  logic [AW-1:0] FWD_ADD = '0;
  logic          IN_READY, WEN, FULL, EMPTY;
  logic [AW-1:0] WADD;
  logic [DW-1:0] DATAIN;
  logic [CW-1:0] COUNT;
`ifdef RF_WBQ_FORWARD_EN
  logic          FWD_HIT;
  logic [DW-1:0] FWD_DATA;
`endif

  rf_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_WADD(IN_WADD), .IN_DATA(IN_DATA), .WEN(WEN), .WADD(WADD),
    .DATAIN(DATAIN), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
`ifdef RF_WBQ_FORWARD_EN
    , .FWD_ADD(FWD_ADD), .FWD_HIT(FWD_HIT), .FWD_DATA(FWD_DATA)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];     // entries the model holds inside the queue
  ent_t sb[$];     // expected write-port transactions awaiting the monitor
  logic m_wen = 1'b0;
  ent_t m_out = '0;
  int   pre;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; head leaves each edge it is non-empty,
  // a new request joins only if the queue was not full before the edge.
  initial forever begin
    @(posedge CLK);
    pre = mq.size();
    if (!RSTN) begin
      mq.delete();
      m_wen = 1'b0;
      m_out = '0;
    end else begin
      m_wen = 1'b0;
      if (pre > 0) begin
        m_out = mq.pop_front();
        m_wen = 1'b1;
        sb.push_back(m_out);
      end
      if (IN_VALID && pre < DEPTH) mq.push_back({IN_WADD, IN_DATA});
    end
  end

  // Monitor on the falling edge.
  initial begin
    ent_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("wen", {31'd0, WEN}, {31'd0, m_wen});
      if (m_wen) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("wadd", {29'd0, WADD}, {29'd0, e.a});
          chk("datain", {16'd0, DATAIN}, {16'd0, e.d});
        end
      end else begin
        chk("wadd_hold", {29'd0, WADD}, {29'd0, m_out.a});
        chk("datain_hold", {16'd0, DATAIN}, {16'd0, m_out.d});
      end
      chk("count", 32'(COUNT), 32'(mq.size()));
      chk("full", {31'd0, FULL}, {31'd0, mq.size() == DEPTH});
      chk("empty", {31'd0, EMPTY}, {31'd0, mq.size() == 0});
      chk("in_ready", {31'd0, IN_READY}, {31'd0, mq.size() != DEPTH});
`ifdef RF_WBQ_FORWARD_EN
      begin
        logic          eh;
        logic [DW-1:0] ed;
        eh = 1'b0;
        ed = '0;
        if (m_wen && m_out.a == FWD_ADD) begin eh = 1'b1; ed = m_out.d; end
        foreach (mq[i]) if (mq[i].a == FWD_ADD) begin eh = 1'b1; ed = mq[i].d; end
        chk("fwd_hit", {31'd0, FWD_HIT}, {31'd0, eh});
        chk("fwd_data", {16'd0, FWD_DATA}, {16'd0, ed});
      end
`endif
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
    @(posedge CLK);
    #2;
    IN_VALID = v;
    IN_WADD  = a;
    IN_DATA  = d;
    RSTN     = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, AW'($urandom), DW'($urandom), 1'b1);
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    idle(2);
    // single request
    drive(1'b1, 3'd3, 16'hA5A5, 1'b1);
    idle(4);
    // back-to-back stream
    for (int a = 0; a < 8; a++) drive(1'b1, AW'(a), DW'(16'h1000 + a), 1'b1);
    idle(3);
    // valid held across reset pulses
    for (int i = 0; i < 6; i++) drive(1'b1, AW'(i), DW'($urandom), (i != 2));
    idle(3);
    // reset discards pending work
    for (int i = 0; i < 3; i++) drive(1'b1, AW'(i + 4), DW'($urandom), 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    idle(5);
    // same-address pair with forwarding lookups
    drive(1'b1, 3'd5, 16'h0011, 1'b1);
    drive(1'b1, 3'd5, 16'h0022, 1'b1);
    FWD_ADD = 3'd5;
    drive(1'b0, '0, '0, 1'b1);
    FWD_ADD = 3'd6;
    idle(2);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 99) > 2));
      FWD_ADD = AW'($urandom);
    end
    idle(6);
    chk("drained", 32'(sb.size() + mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
